sobel_top: RTL and testbench
============================

# sobel_top

Streaming 3x3 Sobel edge-detection core for 8-bit grayscale frames of MAX_ROW x MAX_COL pixels. It sits between the memory controller, which delivers pixels in raster order with a data-enable, and the downstream accumulator/VGA path. It computes the gradient magnitude for every interior pixel and emits it as an 8-bit value with a valid strobe. It signals frame completion to the system controller.

## Interface
- MAX_ROW, 540, frame height in pixels (≥3).
- MAX_COL, 540, frame width in pixels (≥3); sets line-buffer depth.
- THRESHOLD, 128, binarization level; used only when SOBEL_THRESHOLD_EN is defined.

Ports:
- CLK  input  1  single clock, rising edge.
- RST  input  1  reset, synchronous, active-high.
- DATA_I  input  8  input pixel, raster order (row-major, row 0 first).
- DATA_EN_I  input  1  DATA_I valid this cycle.
- CORE_RUN_I  input  1  core enable; input beats are accepted only while high.
- CORE_DONE_O  output  1  one-cycle pulse marking the final output pixel of a frame.
- PIXEL_O  output  8  gradient magnitude.
- PIXEL_EN_O  output  1  PIXEL_O valid.

## Operation
- Beat: a cycle with DATA_EN_I=1 and CORE_RUN_I=1. Other cycles are ignored; no state advances.
- Counters: row (0..MAX_ROW-1) and col (0..MAX_COL-1) track the current beat. col wraps to 0 and row increments at MAX_COL-1.
- Line buffers: two MAX_COL x 8 buffers hold rows r-1 and r-2, indexed by col. They are read and written once per beat.
- Window: 3x3 shift register of columns. Each beat shifts in {row r-2, row r-1, DATA_I} at the current col.
- A window is valid when row≥2 and col≥2. Its center is (row-1, col-1).
- Only interior pixels are produced: (MAX_ROW-2)*(MAX_COL-2) outputs per frame (289444 for 540x540), in raster order of center.
- No output is generated for border pixels.
- Arithmetic, with window p[i][j], i = row offset 0..2 top→bottom, j = col 0..2 left→right:
  - Gx = (p02 + 2·p12 + p22) − (p00 + 2·p10 + p20)
  - Gy = (p20 + 2·p21 + p22) − (p00 + 2·p01 + p02)
  - Gx and Gy are 11-bit signed, range ±1020.
  - mag = |Gx| + |Gy|, 11-bit unsigned, 0..2040.
  - PIXEL_O = min(mag, 255).
- Frame end: the beat at (MAX_ROW-1, MAX_COL-1) produces the last window. The row and col counters then return to 0, so the next beat starts a new frame.
- Line-buffer contents are not cleared between frames; the row≥2 gating makes stale data irrelevant.
- CORE_RUN_I low mid-frame pauses the core: counters, window and buffers are held, and in-flight pipeline outputs still drain.
- RST asserted at any time:
  - clears counters, window valid flags, pipeline valids and all outputs;
  - the frame is abandoned;
  - buffer RAM need not be cleared.

## Timing
- Reset values: PIXEL_O=0, PIXEL_EN_O=0, CORE_DONE_O=0.
- Pipeline has 2 register stages after the beat:
  - at edge k the beat is captured into the window/buffers;
  - at edge k+1 Gx/Gy are registered;
  - at edge k+2 PIXEL_O/PIXEL_EN_O are registered.
- Output appears 2 cycles after the beat that completes the window. PIXEL_EN_O is high for exactly one cycle per valid window.
- Gaps in DATA_EN_I propagate as gaps in PIXEL_EN_O. Back-to-back beats give back-to-back outputs; throughput is 1 pixel/clock.
- CORE_DONE_O is high in the same cycle as the last PIXEL_EN_O of the frame, and only then.
- No backpressure: the downstream path must accept every PIXEL_EN_O.

## Configuration
- SOBEL_THRESHOLD_EN defined: PIXEL_O = 255 if mag > THRESHOLD, else 0. Timing and strobes are unchanged.
- SOBEL_THRESHOLD_EN undefined: PIXEL_O = saturated magnitude as above. THRESHOLD is unused.

## Test plan
- Reset: hold RST high 3 cycles with random inputs → PIXEL_O=0, PIXEL_EN_O=0, CORE_DONE_O=0 throughout.
- Flat frame: 540x540 pixels all 100, continuous beats → exactly 289444 PIXEL_EN_O pulses, all PIXEL_O=0. CORE_DONE_O pulses once, coincident with the last strobe, 2 cycles after the final beat.
- Vertical step: pixel = 0 for col<270, 255 for col≥270 → PIXEL_O=255 for centers at col 269 and 270 on every interior row; 0 elsewhere.
- Gapped input: the step frame with DATA_EN_I toggling every other cycle → identical output sequence, strobes spaced 2 cycles.
- CORE_RUN_I=0 with DATA_EN_I=1 for 1000 cycles → no strobes, no counter advance. Raising CORE_RUN_I then streaming the flat frame → the normal 289444 outputs.
- With SOBEL_THRESHOLD_EN, THRESHOLD=128:
  - horizontal ramp pixel = col/2 gives mag ≤ 8 → all PIXEL_O=0;
  - the step frame gives 255 at cols 269/270.

Source files
------------

// File: rtl/sobel_top.sv
// ----------------------------------------------------------------------------
// sobel_top
//
// Streaming 3x3 Sobel edge detector for 8-bit grayscale frames of
// MAX_ROW x MAX_COL pixels. Pixels arrive in raster order. The core produces
// one gradient magnitude for every interior pixel, in raster order of the
// window center. The final interior output of each frame is flagged with a
// one-cycle done pulse.
//
// Build option:
//   SOBEL_THRESHOLD_EN  when defined, PIXEL_O is binarised
//                       (255 if |Gx|+|Gy| > THRESHOLD, else 0).
//                       When undefined, PIXEL_O is min(|Gx|+|Gy|, 255).
//
// Parameters:
//   MAX_ROW    frame height in pixels (>= 3)
//   MAX_COL    frame width in pixels (>= 3), also the line-buffer depth
//   THRESHOLD  binarisation level, only used with SOBEL_THRESHOLD_EN
//
// Ports:
//   CLK          single clock, rising edge
//   RST          synchronous active-high reset
//   DATA_I       input pixel
//   DATA_EN_I    DATA_I valid this cycle
//   CORE_RUN_I   core enable; input beats are accepted only while high
//   CORE_DONE_O  one-cycle pulse with the last output pixel of a frame
//   PIXEL_O      gradient magnitude (or binarised edge)
//   PIXEL_EN_O   PIXEL_O valid
//
// Latency: the output for a window appears 2 clocks after the beat that
// completes it (window capture -> Gx/Gy register -> output register).
// ----------------------------------------------------------------------------
module sobel_top #(
    parameter int MAX_ROW   = 540,
    parameter int MAX_COL   = 540,
    parameter int THRESHOLD = 128
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] DATA_I,
    input  logic       DATA_EN_I,
    input  logic       CORE_RUN_I,
    output logic       CORE_DONE_O,
    output logic [7:0] PIXEL_O,
    output logic       PIXEL_EN_O
);

    localparam int RW = (MAX_ROW > 1) ? $clog2(MAX_ROW) : 1;
    localparam int CW = (MAX_COL > 1) ? $clog2(MAX_COL) : 1;

    localparam logic [RW-1:0] ROW_LAST = RW'(MAX_ROW - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(MAX_COL - 1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);

`ifdef SOBEL_THRESHOLD_EN
    localparam logic [10:0] THR_LEVEL = 11'(THRESHOLD);
`endif

    // Reject frame geometries too small to hold a 3x3 window and thresholds
    // outside the reachable magnitude range.
    if (MAX_ROW < 3 || MAX_COL < 3 || THRESHOLD < 0 || THRESHOLD > 2040) begin : g_bad_params
        $error("sobel_top: invalid parameter set");
    end

    // ------------------------------------------------------------------------
    // Beat qualification and raster position
    // ------------------------------------------------------------------------
    logic          beat;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          win_ok;
    logic          frame_end;

    assign beat      = DATA_EN_I & CORE_RUN_I;
    assign win_ok    = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
    assign frame_end = (row_q == ROW_LAST) && (col_q == COL_LAST);

    // Column wraps at the end of each line and bumps the row; the last pixel
    // of the frame wraps both, so the next beat starts a new frame.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (beat) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    // ------------------------------------------------------------------------
    // Line buffers
    // lbuf_mid_q holds row r-1 and lbuf_top_q holds row r-2, both indexed by
    // column. Each beat reads the old column entries and pushes the data down
    // one row: mid moves to top, the incoming pixel becomes the new mid.
    // Contents are deliberately left uninitialised; the row >= 2 window gate
    // keeps stale or unknown entries from ever reaching the output.
    // ------------------------------------------------------------------------
    logic [7:0] lbuf_top_q [MAX_COL];
    logic [7:0] lbuf_mid_q [MAX_COL];
    logic [7:0] top_rd;
    logic [7:0] mid_rd;

    assign top_rd = lbuf_top_q[col_q];
    assign mid_rd = lbuf_mid_q[col_q];

    always_ff @(posedge CLK) begin
        if (beat) begin
            lbuf_top_q[col_q] <= mid_rd;
            lbuf_mid_q[col_q] <= DATA_I;
        end
    end

    // ------------------------------------------------------------------------
    // 3x3 window
    // win_q[i][j]: i = row offset (0 top, 2 bottom), j = column (0 left /
    // oldest, 2 right / newest). Each beat shifts one new column in from the
    // right. The window and its valid flag hold while no beat arrives.
    // win_vld_q is a one-cycle strobe so a held window is only emitted once.
    // ------------------------------------------------------------------------
    logic [7:0] win_q [3][3];
    logic       win_vld_q;
    logic       win_last_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= '0;
                end
            end
            win_vld_q  <= 1'b0;
            win_last_q <= 1'b0;
        end else begin
            win_vld_q  <= beat & win_ok;
            win_last_q <= beat & frame_end;
            if (beat) begin
                for (int i = 0; i < 3; i++) begin
                    win_q[i][0] <= win_q[i][1];
                    win_q[i][1] <= win_q[i][2];
                end
                win_q[0][2] <= top_rd;
                win_q[1][2] <= mid_rd;
                win_q[2][2] <= DATA_I;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: signed gradients
    // Each side of a kernel is a weighted column/row sum of at most 1020, so
    // the 10-bit partial sums are zero-extended to 11 bits before the
    // subtraction to give the full +/-1020 signed range.
    // ------------------------------------------------------------------------
    logic        [9:0]  gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [10:0] gx_d, gy_d;
    logic signed [10:0] gx_q, gy_q;
    logic               s1_vld_q;
    logic               s1_last_q;

    always_comb begin
        gx_pos = {2'b00, win_q[0][2]} + {1'b0, win_q[1][2], 1'b0} + {2'b00, win_q[2][2]};
        gx_neg = {2'b00, win_q[0][0]} + {1'b0, win_q[1][0], 1'b0} + {2'b00, win_q[2][0]};
        gy_pos = {2'b00, win_q[2][0]} + {1'b0, win_q[2][1], 1'b0} + {2'b00, win_q[2][2]};
        gy_neg = {2'b00, win_q[0][0]} + {1'b0, win_q[0][1], 1'b0} + {2'b00, win_q[0][2]};
        gx_d   = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
        gy_d   = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            gx_q      <= '0;
            gy_q      <= '0;
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
        end else begin
            s1_vld_q  <= win_vld_q;
            s1_last_q <= win_vld_q & win_last_q;
            if (win_vld_q) begin
                gx_q <= gx_d;
                gy_q <= gy_d;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: magnitude and output formatting
    // |Gx| and |Gy| are each at most 1020, so their sum fits 11 bits unsigned.
    // ------------------------------------------------------------------------
    logic [10:0] gx_abs;
    logic [10:0] gy_abs;
    logic [10:0] mag;
    logic [7:0]  pix_d;
    logic [7:0]  pix_q;
    logic        pix_en_q;
    logic        done_q;

    always_comb begin
        gx_abs = gx_q[10] ? unsigned'(-gx_q) : unsigned'(gx_q);
        gy_abs = gy_q[10] ? unsigned'(-gy_q) : unsigned'(gy_q);
        mag    = gx_abs + gy_abs;
`ifdef SOBEL_THRESHOLD_EN
        pix_d  = (mag > THR_LEVEL) ? 8'hFF : 8'h00;
`else
        pix_d  = (mag > 11'd255) ? 8'hFF : mag[7:0];
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pix_q    <= '0;
            pix_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            pix_en_q <= s1_vld_q;
            done_q   <= s1_vld_q & s1_last_q;
            if (s1_vld_q) begin
                pix_q <= pix_d;
            end
        end
    end

    assign PIXEL_O     = pix_q;
    assign PIXEL_EN_O  = pix_en_q;
    assign CORE_DONE_O = done_q;

endmodule

// File: tb/tb_sobel_top.sv
// ----------------------------------------------------------------------------
// tb_sobel_top
//
// Self-checking bench for sobel_top on a small 4x5 frame (2x3 = 6 interior
// outputs per frame). A table of directed frame patterns with hand-computed
// outputs is streamed through the core, followed by hand-written sequences
// for reset, run-low stalls and a mid-frame reset.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sobel_top;

    localparam int ROWS = 4;
    localparam int COLS = 5;
    localparam int NOUT = (ROWS - 2) * (COLS - 2);
    localparam int THR  = 128;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] DATA_I = '0;
    logic       DATA_EN_I = 1'b0;
    logic       CORE_RUN_I = 1'b0;
    logic       CORE_DONE_O;
    logic [7:0] PIXEL_O;
    logic       PIXEL_EN_O;

    sobel_top #(
        .MAX_ROW  (ROWS),
        .MAX_COL  (COLS),
        .THRESHOLD(THR)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .DATA_I     (DATA_I),
        .DATA_EN_I  (DATA_EN_I),
        .CORE_RUN_I (CORE_RUN_I),
        .CORE_DONE_O(CORE_DONE_O),
        .PIXEL_O    (PIXEL_O),
        .PIXEL_EN_O (PIXEL_EN_O)
    );

    always #5 CLK = ~CLK;

    // Pattern codes for the frame generator
    localparam int P_FLAT  = 0;
    localparam int P_VSTEP = 1;
    localparam int P_HSTEP = 2;
    localparam int P_CRAMP = 3;
    localparam int P_CDESC = 4;
    localparam int P_RDESC = 5;
    localparam int P_DIAG  = 6;
    localparam int P_IMP   = 7;

    // Stream modes: continuous, every-other-cycle gaps, run-low pause mid-frame
    localparam int M_CONT  = 0;
    localparam int M_GAP   = 1;
    localparam int M_PAUSE = 2;

    typedef struct packed {
        logic [3:0]            pat;
        logic [7:0]            k;
        logic [1:0]            mode;
        logic [NOUT-1:0][7:0]  expPix;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] outQ[$];
    int         outCyc[$];
    int         doneCnt = 0;
    int         doneIdx = -1;
    int         doneCyc = -100;
    logic       doneEn = 1'b0;
    int         lastBeatCyc = 0;

    // Cycle counter, advanced on each active edge
    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Output monitor, sampling on the falling edge
    initial forever begin
        @(negedge CLK);
        if (PIXEL_EN_O === 1'b1) begin
            outQ.push_back(PIXEL_O);
            outCyc.push_back(cyc);
        end
        if (CORE_DONE_O === 1'b1) begin
            doneCnt++;
            doneIdx = outQ.size();
            doneEn  = PIXEL_EN_O;
            doneCyc = cyc;
        end
    end

    function automatic int pixVal(input int pat, input int k, input int r, input int c);
        case (pat)
            P_FLAT:  return k;
            P_VSTEP: return (c >= 2) ? 255 : 0;
            P_HSTEP: return (r >= 3) ? k : 0;
            P_CRAMP: return c * k;
            P_CDESC: return (4 - c) * k;
            P_RDESC: return (3 - r) * k;
            P_DIAG:  return (r + c) * k;
            P_IMP:   return (r == 1 && c == 1) ? k : 0;
            default: return 0;
        endcase
    endfunction

    function automatic vec_t mkVec(input int pat, input int k, input int mode,
                                   input int e0, input int e1, input int e2,
                                   input int e3, input int e4, input int e5);
        vec_t v;
        v.pat       = 4'(pat);
        v.k         = 8'(k);
        v.mode      = 2'(mode);
        v.expPix[0] = 8'(e0);
        v.expPix[1] = 8'(e1);
        v.expPix[2] = 8'(e2);
        v.expPix[3] = 8'(e3);
        v.expPix[4] = 8'(e4);
        v.expPix[5] = 8'(e5);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic clearMonitor();
        outQ.delete();
        outCyc.delete();
        doneCnt = 0;
        doneIdx = -1;
        doneEn  = 1'b0;
        doneCyc = -100;
    endtask

    // Streams the first nBeats pixels of a pattern in raster order
    task automatic applyStimulus(input int pat, input int k, input int mode, input int nBeats);
        for (int i = 0; i < nBeats; i++) begin
            int r;
            int c;
            r = (i / COLS) % ROWS;
            c = i % COLS;
            @(negedge CLK);
            DATA_I      = 8'(pixVal(pat, k, r, c));
            DATA_EN_I   = 1'b1;
            CORE_RUN_I  = 1'b1;
            lastBeatCyc = cyc + 1;
            if (mode == M_GAP) begin
                @(negedge CLK);
                DATA_EN_I = 1'b0;
                DATA_I    = 8'($urandom);
            end
            if (mode == M_PAUSE && i == 13) begin
                for (int j = 0; j < 8; j++) begin
                    @(negedge CLK);
                    CORE_RUN_I = 1'b0;
                    DATA_EN_I  = 1'b1;
                    DATA_I     = 8'($urandom);
                end
            end
        end
        @(negedge CLK);
        DATA_EN_I  = 1'b0;
        CORE_RUN_I = 1'b1;
        DATA_I     = '0;
    endtask

    // Lets the pipeline drain, then checks one frame's worth of outputs
    task automatic checkFrame(input string name, input logic [NOUT-1:0][7:0] expPix, input int spacing);
        repeat (6) @(negedge CLK);
        checkOutput({name, " count"}, 32'(outQ.size()), NOUT);
        for (int i = 0; i < NOUT; i++) begin
            logic [7:0] e;
            e = expPix[i];
`ifdef SOBEL_THRESHOLD_EN
            e = (int'(e) > THR) ? 8'hFF : 8'h00;
`endif
            checkOutput($sformatf("%s pix%0d", name, i),
                        (i < outQ.size()) ? {24'b0, outQ[i]} : 32'hDEAD, {24'b0, e});
        end
        checkOutput({name, " done count"}, 32'(doneCnt), 1);
        checkOutput({name, " done index"}, 32'(doneIdx), NOUT);
        checkOutput({name, " done with strobe"}, {31'b0, doneEn}, 1);
        checkOutput({name, " done latency"}, 32'(doneCyc - lastBeatCyc), 2);
        if (spacing > 0) begin
            for (int i = 0; i + 1 < outCyc.size(); i++) begin
                if ((i % (COLS - 2)) != (COLS - 3)) begin
                    checkOutput($sformatf("%s spacing%0d", name, i),
                                32'(outCyc[i+1] - outCyc[i]), 32'(spacing));
                end
            end
        end
        clearMonitor();
    endtask

    initial begin
        vec_t vecs[12];

        vecs[0]  = mkVec(P_FLAT,  100, M_CONT,    0,   0,   0,   0,   0,   0);
        vecs[1]  = mkVec(P_VSTEP,   0, M_CONT,  255, 255,   0, 255, 255,   0);
        vecs[2]  = mkVec(P_VSTEP,   0, M_GAP,   255, 255,   0, 255, 255,   0);
        vecs[3]  = mkVec(P_HSTEP,  40, M_CONT,    0,   0,   0, 160, 160, 160);
        vecs[4]  = mkVec(P_CRAMP,  10, M_CONT,   80,  80,  80,  80,  80,  80);
        vecs[5]  = mkVec(P_CDESC,  10, M_CONT,   80,  80,  80,  80,  80,  80);
        vecs[6]  = mkVec(P_RDESC,  20, M_CONT,  160, 160, 160, 160, 160, 160);
        vecs[7]  = mkVec(P_DIAG,   10, M_CONT,  160, 160, 160, 160, 160, 160);
        vecs[8]  = mkVec(P_DIAG,   16, M_CONT,  255, 255, 255, 255, 255, 255);
        vecs[9]  = mkVec(P_DIAG,   15, M_CONT,  240, 240, 240, 240, 240, 240);
        vecs[10] = mkVec(P_IMP,    50, M_CONT,    0, 100,   0, 100, 100,   0);
        vecs[11] = mkVec(P_VSTEP,   0, M_PAUSE, 255, 255,   0, 255, 255,   0);

        // Reset held for 3 cycles with random inputs: outputs stay at zero
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checkOutput($sformatf("reset pixel c%0d", i), {24'b0, PIXEL_O}, 0);
            checkOutput($sformatf("reset pixel_en c%0d", i), {31'b0, PIXEL_EN_O}, 0);
            checkOutput($sformatf("reset done c%0d", i), {31'b0, CORE_DONE_O}, 0);
            DATA_I     = 8'($urandom);
            DATA_EN_I  = 1'($urandom);
            CORE_RUN_I = 1'($urandom);
        end
        @(negedge CLK);
        RST        = 1'b0;
        DATA_EN_I  = 1'b0;
        CORE_RUN_I = 1'b0;
        @(negedge CLK);
        clearMonitor();

        // CORE_RUN_I low with DATA_EN_I high: nothing advances
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            CORE_RUN_I = 1'b0;
            DATA_EN_I  = 1'b1;
            DATA_I     = 8'($urandom);
        end
        @(negedge CLK);
        DATA_EN_I = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("runlow strobes", 32'(outQ.size()), 0);
        checkOutput("runlow done", 32'(doneCnt), 0);
        applyStimulus(P_VSTEP, 0, M_CONT, ROWS * COLS);
        checkFrame("runlow vstep", vecs[1].expPix, 1);

        // Directed frame table
        for (int v = 0; v < 12; v++) begin
            applyStimulus(int'(vecs[v].pat), int'(vecs[v].k), int'(vecs[v].mode), ROWS * COLS);
            checkFrame($sformatf("vec%0d", v), vecs[v].expPix,
                       (vecs[v].mode == M_GAP) ? 2 : ((vecs[v].mode == M_CONT) ? 1 : 0));
        end

        // Reset one cycle after the first window of a frame: the in-flight
        // result is dropped and the next frame starts from row 0 / col 0
        applyStimulus(P_DIAG, 10, M_CONT, 13);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        checkOutput("midreset strobes", 32'(outQ.size()), 0);
        checkOutput("midreset done", 32'(doneCnt), 0);
        clearMonitor();
        applyStimulus(P_VSTEP, 0, M_CONT, ROWS * COLS);
        checkFrame("midreset vstep", vecs[1].expPix, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench always terminates
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running, want finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
